// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and constants for the probe trace buffer
package trace_pkg;

  localparam int TRACE_XLEN = 32;
  localparam int REC_W      = 5 * TRACE_XLEN + 16;

  localparam logic [1:0] MODE_ALL     = 2'd0;
  localparam logic [1:0] MODE_WB_ONLY = 2'd1;
  localparam logic [1:0] MODE_TRIGGER = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  // First member lands in the MSBs, so rs2_data ends up at bit 0.
  typedef struct packed {
    logic                  we;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [TRACE_XLEN-1:0] pc;
    logic [TRACE_XLEN-1:0] insn;
    logic [TRACE_XLEN-1:0] wdata;
    logic [TRACE_XLEN-1:0] rs1_data;
    logic [TRACE_XLEN-1:0] rs2_data;
  } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - record FIFO with drop/overwrite policy and registered head
module trace_fifo #(
  parameter int W     = 176,
  parameter int DEPTH = 16,
  parameter int WRAP  = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [W-1:0]             out_rec,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_next;
  logic [CW-1:0] count_next;
  logic [W-1:0]  head_next;
  logic          full;
  logic          pop;
  logic          do_write;
  logic          rd_adv;
  logic          lost;

  assign out_valid = (count != '0);

  // Decide write/advance/drop for this cycle and the head entry that follows it.
  always_comb begin
    full       = (count == CW'(DEPTH));
    pop        = out_valid && out_ready;
    do_write   = push && (!full || pop || (WRAP != 0));
    rd_adv     = pop || (push && full && (WRAP != 0));
    lost       = push && full && !pop;
    rd_next    = rd_ptr + AW'(rd_adv);
    count_next = count;
    if (do_write && !rd_adv) count_next = count + CW'(1);
    else if (!do_write && rd_adv) count_next = count - CW'(1);
    // A write landing on the new head slot must be forwarded, mem is not yet updated.
    head_next = (do_write && (wr_ptr == rd_next)) ? din : mem[rd_next];
  end

  // Storage array; contents need no reset since pointers/count gate visibility.
  always_ff @(posedge clock) begin
    if (do_write && !clear) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy, loss counter and registered head.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
      out_rec    <= '0;
    end else if (clear) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
      out_rec    <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= rd_next;
      count   <= count_next;
      out_rec <= head_next;
      if (lost && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: rtl/probe_trace_buffer.sv
// rtl/probe_trace_buffer.sv - capture FSM and push qualification for core probe tracing
module probe_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int WRAP  = 0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              cfg_mode,
  input  logic [XLEN-1:0]         cfg_trig_pc,
  input  logic                    arm,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    probe_valid,
  input  logic [XLEN-1:0]         probe_pc,
  input  logic [XLEN-1:0]         probe_insn,
  input  logic                    probe_we,
  input  logic [4:0]              probe_rd,
  input  logic [XLEN-1:0]         probe_wdata,
  input  logic [4:0]              probe_rs1,
  input  logic [4:0]              probe_rs2,
  input  logic [XLEN-1:0]         probe_rs1_data,
  input  logic [XLEN-1:0]         probe_rs2_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [5*XLEN+15:0]      out_rec,
  output logic [$clog2(DEPTH):0]  count,
  output logic [15:0]             drop_count,
  output logic [1:0]              state
);

  state_t cur_st;
  state_t nxt_st;
  logic   trig_hit;
  logic   push;
  logic [5*XLEN+15:0] rec;

  assign state = cur_st;
  assign rec   = {probe_we, probe_rd, probe_rs1, probe_rs2, probe_pc,
                  probe_insn, probe_wdata, probe_rs1_data, probe_rs2_data};

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cur_st <= ST_IDLE;
    else        cur_st <= nxt_st;
  end

  // Next state and push qualification; the trigger cycle itself is captured.
  always_comb begin
    nxt_st   = cur_st;
    trig_hit = (cur_st == ST_ARMED) && probe_valid && (probe_pc == cfg_trig_pc);
    push     = probe_valid && ((cur_st == ST_CAPTURE) || trig_hit) &&
               ((cfg_mode != MODE_WB_ONLY) || probe_we);
    if (stop) begin
      nxt_st = ST_IDLE;
    end else begin
      case (cur_st)
        ST_IDLE:    if (arm) nxt_st = (cfg_mode == MODE_TRIGGER) ? ST_ARMED : ST_CAPTURE;
        ST_ARMED:   if (trig_hit) nxt_st = ST_CAPTURE;
        ST_CAPTURE: nxt_st = ST_CAPTURE;
        default:    nxt_st = ST_IDLE;
      endcase
    end
  end

  trace_fifo #(
    .W     (5 * XLEN + 16),
    .DEPTH (DEPTH),
    .WRAP  (WRAP)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .clear      (clear),
    .push       (push),
    .din        (rec),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_rec    (out_rec),
    .count      (count),
    .drop_count (drop_count)
  );

endmodule

// File: doc/probe_trace_buffer.md
# probe_trace_buffer

Parametrised, synthesizable successor to the core's one-shot probe dump. It captures per-cycle architectural probe records (PC, INSN, register-file write port, both register-file read ports) from the core's probe signal set into a DEPTH-entry FIFO. Capture has three modes: every cycle, writeback-only, or start-on-PC-trigger. The bench or a debug port drains records through a valid/ready interface. The block sits beside `core` inside `design_wrapper`.

## Interface
Parameters:
- XLEN, 32, data/PC width
- DEPTH, 16, FIFO entries; power of two, ≥2
- WRAP, 0, full-buffer policy: 0 = drop newest, 1 = overwrite oldest

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- cfg_mode  in  2  0 ALL, 1 WB_ONLY, 2 TRIGGER; 3 behaves as ALL
- cfg_trig_pc  in  XLEN  trigger PC for TRIGGER mode
- arm, stop, clear  in  1 each  control pulses
- probe_valid  in  1  probe fields valid this cycle
- probe_pc, probe_insn  in  XLEN each
- probe_we  in  1;  probe_rd  in  5;  probe_wdata  in  XLEN
- probe_rs1, probe_rs2  in  5 each;  probe_rs1_data, probe_rs2_data  in  XLEN each
- out_valid  out  1;  out_ready  in  1;  out_rec  out  REC_W  packed trace_rec_t (REC_W = 5·XLEN+16)
- count  out  $clog2(DEPTH)+1  current occupancy
- drop_count  out  16  saturating count of lost records
- state  out  2  FSM state

## Operation
- FSM states: IDLE(0), ARMED(1), CAPTURE(2).
  - IDLE + arm → CAPTURE if cfg_mode≠TRIGGER, otherwise → ARMED.
  - ARMED + probe_valid && probe_pc==cfg_trig_pc → CAPTURE. The matching record is captured in that same cycle.
  - Any state + stop → IDLE. stop beats arm in the same cycle. arm is ignored outside IDLE.
- Push condition: probe_valid, and either state==CAPTURE or the ARMED trigger match fires. In WB_ONLY mode, probe_we must also be 1. Records with probe_rd==0 are still captured.
- Record order, LSB up: rs2_data, rs1_data, wdata, insn, pc, rs2, rs1, rd, we.
- Pop occurs when out_valid && out_ready. Draining is allowed in every state.
- Full, push, no pop:
  - WRAP=0: record discarded.
  - WRAP=1: oldest entry overwritten and the read pointer advances.
  - Both cases increment drop_count, saturating at 0xFFFF.
- Full with push and pop in the same cycle: both succeed, count unchanged, no drop.
- Empty with push and pop in the same cycle: pop has no effect, since out_valid is 0.
- clear: resets pointers, count and drop_count, and discards any same-cycle push. State is unchanged. clear beats push and pop.
- Pointers wrap modulo DEPTH. count saturates at DEPTH by construction.

## Timing
- Reset values: out_valid=0, out_rec=0, count=0, drop_count=0, state=IDLE, pointers=0.
- Asserting reset mid-capture flushes the buffer immediately, asynchronously.
- Push latency: a record written at edge N is visible on out_rec with out_valid=1 after edge N. First-word is not fall-through; out_rec is the registered head.
- out_rec is stable while out_valid && !out_ready.
- After a pop, the next entry, if any, is presented in the following cycle. Throughput is 1 record/cycle.
- count and drop_count update on the same edge as the push or pop.
- state changes on the edge after arm/stop/trigger. The capture decision uses the pre-edge state, except for the trigger-match cycle.

## Structure
- Package `trace_pkg`: trace_rec_t packed struct, mode constants (MODE_ALL, MODE_WB_ONLY, MODE_TRIGGER), state enum, and REC_W.
- One sub-module, `trace_fifo`: a parametrised DEPTH×REC_W storage with wrap/overwrite support and registered head.
- The FSM and push qualification live in the top level.

## Test plan
- ALL mode: arm, then 5 valid probes with pc=0x01000000+4i → 5 records popped in order; count returns to 0; drop_count=0.
- WB_ONLY mode: alternate probe_we 1/0 over 8 cycles → exactly 4 records, all with we=1.
- TRIGGER mode with cfg_trig_pc=0x0100000C: pcs 0x01000000..0x01000018 → first record pc=0x0100000C; 4 records total; state goes ARMED→CAPTURE.
- Overflow, DEPTH=16, out_ready=0, 20 pushes:
  - WRAP=0: head pc is the first pushed, drop_count=4.
  - WRAP=1: head is the 5th pushed, drop_count=4.
- Full with simultaneous push and pop, and out_ready toggled every cycle → no loss, count stays 16, out_rec stable while stalled.
- Controls:
  - stop+arm in the same cycle → IDLE.
  - clear during a push → count=0.
  - reset low mid-capture → all outputs at reset values immediately.
